// File: rtl/mac_requant_pkg.sv
// Shared widths, limits and FSM state type for the MAC requantization path.
package mac_requant_pkg;

    localparam int IN_W      = 19;
    localparam int ACC_W     = 32;
    localparam int MULT_W    = 16;
    localparam int SHIFT_W   = 5;
    localparam int OUT_W     = 8;
    localparam int MAX_BEATS = 256;

    localparam int PROD_W = ACC_W + MULT_W + 1;
    localparam int CNT_W  = $clog2(MAX_BEATS);

    localparam logic signed [PROD_W-1:0] OUT_MAX = PROD_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [PROD_W-1:0] OUT_MIN = PROD_W'(-(2 ** (OUT_W - 1)));

    typedef enum logic [1:0] {
        ACC  = 2'd0,
        MUL  = 2'd1,
        RND  = 2'd2,
        HOLD = 2'd3
    } state_t;

endpackage

// File: rtl/mac_requant_round_sat.sv
// Combinational shift, optional round-half-up and int8 saturation.
// Round-half-up is enabled by defining MAC_REQUANT_ROUND_EN; otherwise truncation toward -inf.
import mac_requant_pkg::*;

module requant_round_sat (
    input  logic [PROD_W-1:0]  prod,
    input  logic [SHIFT_W-1:0] shift,
    output logic [OUT_W-1:0]   value,
    output logic               clip
);

    localparam logic [PROD_W-1:0] ROUND_ONE = PROD_W'(1);

    logic signed [PROD_W-1:0] biased;
    logic signed [PROD_W-1:0] shifted;

    // Apply rounding offset, shift, then clamp to the output range.
    always_comb begin
        biased = $signed(prod);
`ifdef MAC_REQUANT_ROUND_EN
        if (shift != {SHIFT_W{1'b0}}) begin
            biased = $signed(prod) + $signed(ROUND_ONE << (shift - SHIFT_W'(1)));
        end else begin
            biased = $signed(prod);
        end
`endif
        shifted = biased >>> shift;
        if (shifted > OUT_MAX) begin
            value = OUT_MAX[OUT_W-1:0];
            clip  = 1'b1;
        end else if (shifted < OUT_MIN) begin
            value = OUT_MIN[OUT_W-1:0];
            clip  = 1'b1;
        end else begin
            value = shifted[OUT_W-1:0];
            clip  = 1'b0;
        end
    end

endmodule

// File: rtl/mac_requant.sv
// Accumulates a frame of signed dot products plus bias and requantizes it to int8.
// Rounding mode selected at build time by MAC_REQUANT_ROUND_EN.
import mac_requant_pkg::*;

module mac_requant (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    input  logic [IN_W-1:0]    i_data,
    input  logic               i_last,
    input  logic [ACC_W-1:0]   i_bias,
    input  logic [MULT_W-1:0]  i_mult,
    input  logic [SHIFT_W-1:0] i_shift,
    output logic               o_ready,
    output logic               o_valid,
    output logic [OUT_W-1:0]   o_data,
    output logic               o_sat,
    input  logic               i_ready,
    output logic               o_drop,
    output logic               o_ovf
);

    state_t                   state;
    logic signed [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]         count;
    logic [MULT_W-1:0]        mult;
    logic [SHIFT_W-1:0]       shift;
    logic signed [PROD_W-1:0] prod;

    logic                     beat;
    logic                     first;
    logic                     at_limit;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [MULT_W:0]   mult_ext;
    logic [OUT_W-1:0]         rs_value;
    logic                     rs_clip;

    assign o_ready  = (state == ACC);
    assign beat     = i_valid && o_ready;
    assign first    = (count == {CNT_W{1'b0}});
    assign at_limit = (count == CNT_W'(MAX_BEATS - 1));
    // The first beat of a frame starts from the bias instead of the running sum.
    assign acc_next = (first ? $signed(i_bias) : acc) + ACC_W'($signed(i_data));
    assign mult_ext = {1'b0, mult};

    requant_round_sat u_round_sat (
        .prod  (prod),
        .shift (shift),
        .value (rs_value),
        .clip  (rs_clip)
    );

    // Frame FSM: accumulate, multiply, round/saturate, hold until handshake.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= ACC;
            acc     <= '0;
            count   <= '0;
            mult    <= '0;
            shift   <= '0;
            prod    <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_sat   <= 1'b0;
            o_drop  <= 1'b0;
            o_ovf   <= 1'b0;
        end else begin
            if (i_valid && !o_ready) begin
                o_drop <= 1'b1;
            end
            case (state)
                ACC: begin
                    if (beat) begin
                        acc   <= acc_next;
                        count <= count + CNT_W'(1);
                        if (first) begin
                            mult  <= i_mult;
                            shift <= i_shift;
                        end
                        if (i_last || at_limit) begin
                            state <= MUL;
                            if (!i_last) begin
                                o_ovf <= 1'b1;
                            end
                        end
                    end
                end
                MUL: begin
                    prod  <= PROD_W'(acc) * PROD_W'(mult_ext);
                    state <= RND;
                end
                RND: begin
                    o_data  <= rs_value;
                    o_sat   <= rs_clip;
                    o_valid <= 1'b1;
                    state   <= HOLD;
                end
                HOLD: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        acc     <= '0;
                        count   <= '0;
                        state   <= ACC;
                    end
                end
                default: begin
                    state <= ACC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_requant.sv
// Self-checking bench for mac_requant: directed plan items plus random frames against a model.
module tb_mac_requant;

    logic        clk;
    logic        rst;
    logic        i_valid;
    logic [18:0] i_data;
    logic        i_last;
    logic [31:0] i_bias;
    logic [15:0] i_mult;
    logic [4:0]  i_shift;
    logic        o_ready;
    logic        o_valid;
    logic [7:0]  o_data;
    logic        o_sat;
    logic        i_ready;
    logic        o_drop;
    logic        o_ovf;

    int passed = 0;
    int total  = 0;
    int beats[$];
    longint exp_d;
    bit     exp_s;

    mac_requant dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (i_valid),
        .i_data  (i_data),
        .i_last  (i_last),
        .i_bias  (i_bias),
        .i_mult  (i_mult),
        .i_shift (i_shift),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_sat   (o_sat),
        .i_ready (i_ready),
        .o_drop  (o_drop),
        .o_ovf   (o_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Reference: wrap sum to 32 bits, multiply, shift (optionally round), clamp to int8.
    function automatic longint model(input longint sum, input longint mult, input int sh, output bit sat);
        longint acc, prod, r;
        acc  = longint'(int'(sum));
        prod = acc * mult;
`ifdef MAC_REQUANT_ROUND_EN
        if (sh > 0) prod = prod + (longint'(1) <<< (sh - 1));
`endif
        r   = prod >>> sh;
        sat = (r > 127) || (r < -128);
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return r;
    endfunction

    // Drive the beats queue as one frame; leaves the final beat on the bus.
    task automatic drive_frame(input logic [31:0] bias, input logic [15:0] mult, input logic [4:0] sh,
                               input bit use_last, input bit gaps);
        longint sum;
        sum = longint'($signed(bias));
        foreach (beats[i]) begin
            @(negedge clk);
            if (gaps && ($urandom_range(0, 1) == 1)) begin
                i_valid = 1'b0;
                @(negedge clk);
            end
            i_valid = 1'b1;
            i_data  = 19'(beats[i]);
            i_last  = use_last && (i == beats.size() - 1);
            if (i == 0) begin
                i_bias = bias; i_mult = mult; i_shift = sh;
            end else begin
                i_bias = $urandom(); i_mult = 16'($urandom()); i_shift = 5'($urandom());
            end
            sum = sum + beats[i];
        end
        exp_d = model(sum, longint'(mult), int'(sh), exp_s);
    endtask

    task automatic await_result(input string tag);
        int lat;
        @(negedge clk);
        i_valid = 1'b0;
        i_last  = 1'b0;
        lat = 1;
        while (!o_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, 3);
        check({tag, "_data"}, $signed(o_data), exp_d);
        check({tag, "_sat"}, o_sat, exp_s);
    endtask

    task automatic handshake(input string tag);
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        check({tag, "_valid_clear"}, o_valid, 0);
        check({tag, "_ready_back"}, o_ready, 1);
    endtask

    task automatic one_beat(input string tag, input int d, input logic [31:0] bias,
                            input logic [15:0] mult, input logic [4:0] sh);
        beats = '{d};
        drive_frame(bias, mult, sh, 1'b1, 1'b0);
        await_result(tag);
        handshake(tag);
    endtask

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_data = '0; i_last = 1'b0;
        i_bias = '0; i_mult = '0; i_shift = '0; i_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", o_valid, 0);
        check("rst_data", $signed(o_data), 0);
        check("rst_sat", o_sat, 0);
        check("rst_drop", o_drop, 0);
        check("rst_ovf", o_ovf, 0);
        check("rst_ready", o_ready, 1);

        one_beat("single_1000", 1000, 32'd0, 16'd1, 5'd3);
        one_beat("pos5", 5, 32'd0, 16'd1, 5'd1);
        one_beat("neg5", -5, 32'd0, 16'd1, 5'd1);

        beats = '{100, -50, 25, 25};
        drive_frame(32'd10, 16'd3, 5'd2, 1'b1, 1'b0);
        await_result("four_beat");
        handshake("four_beat");

        one_beat("sat_pos", 200000, 32'd0, 16'd1, 5'd0);
        one_beat("sat_neg", -200000, 32'd0, 16'd1, 5'd0);
        one_beat("mult0", 123456, 32'd77, 16'd0, 5'd4);
        check("no_drop_yet", o_drop, 0);

        // Backpressure with beats arriving while the result is held.
        beats = '{42};
        drive_frame(32'd0, 16'd1, 5'd0, 1'b1, 1'b0);
        await_result("bp");
        for (int k = 0; k < 5; k++) begin
            i_valid = 1'b1;
            i_data  = 19'($urandom());
            @(negedge clk);
            check("bp_data_stable", $signed(o_data), exp_d);
            check("bp_ready_low", o_ready, 0);
            check("bp_valid_held", o_valid, 1);
        end
        i_valid = 1'b0;
        check("bp_drop", o_drop, 1);
        handshake("bp");

        // Forced frame end after MAX_BEATS beats without last.
        check("ovf_before", o_ovf, 0);
        beats = {};
        for (int k = 0; k < 256; k++) beats.push_back(1);
        drive_frame(32'd0, 16'd1, 5'd8, 1'b0, 1'b0);
        await_result("forced");
        check("forced_ovf", o_ovf, 1);
        handshake("forced");

        // Randomized frames with idle gaps.
        for (int f = 0; f < 25; f++) begin
            int n;
            n = $urandom_range(1, 6);
            beats = {};
            for (int k = 0; k < n; k++) beats.push_back(int'($urandom_range(0, 524287)) - 262144);
            drive_frame($urandom(), 16'($urandom_range(0, 65535)), 5'($urandom_range(0, 31)), 1'b1, 1'b1);
            await_result("rand");
            handshake("rand");
        end

        // Reset mid-frame discards the partial sum.
        beats = '{100, 100, 100};
        drive_frame(32'd5, 16'd1, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        i_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_mid_valid", o_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_ready", o_ready, 1);
        one_beat("after_mid_rst", 8, 32'd0, 16'd1, 5'd0);

        // Reset while holding a result.
        beats = '{50};
        drive_frame(32'd0, 16'd1, 5'd0, 1'b1, 1'b0);
        await_result("pre_hold_rst");
        rst = 1'b1;
        #1;
        check("rst_hold_valid", o_valid, 0);
        check("rst_hold_data", $signed(o_data), 0);
        check("rst_hold_drop", o_drop, 0);
        check("rst_hold_ovf", o_ovf, 0);
        @(negedge clk);
        rst = 1'b0;
        one_beat("after_hold_rst", -9, 32'd0, 16'd1, 5'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
